// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake and ALU drive bundle for alu_issue_ctrl.
//   instr_valid/instr_data/instr_ready : upstream instruction byte handshake
//   alu_a/alu_b/alu_opr/alu_en         : ALU operands, opcode and enable
//   alu_imm/alu_imm_en                 : immediate byte and operand-B select
//   alu_result                         : ALU combinational result
// The slave modport is the controller; the master modport is the surrounding
// system (instruction source plus ALU).
interface alu_issue_ctrl_if;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned OPR_W  = 3;

    logic              instr_valid;
    logic [DATA_W-1:0] instr_data;
    logic              instr_ready;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OPR_W-1:0]  alu_opr;
    logic              alu_en;
    logic [DATA_W-1:0] alu_imm;
    logic              alu_imm_en;
    logic [DATA_W-1:0] alu_result;

    modport slave (
        input  instr_valid, instr_data, alu_result,
        output instr_ready, alu_a, alu_b, alu_opr, alu_en, alu_imm, alu_imm_en
    );

    modport master (
        output instr_valid, instr_data, alu_result,
        input  instr_ready, alu_a, alu_b, alu_opr, alu_en, alu_imm, alu_imm_en
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/control stage for the 8-bit ALU: accepts instruction bytes, decodes
// them, owns a 4 x 8-bit register file, drives the ALU for one execute cycle
// and writes the result back.
//   clk, rst  : clock and synchronous active-high reset
//   bus       : instruction handshake and ALU drive (slave modport)
//   exec_done : one-cycle pulse while an instruction executes
//   div0_err  : sticky divide-by-zero flag, cleared only by reset
//   dbg_sel   : debug register select
//   dbg_data  : R[dbg_sel], combinational
module alu_issue_ctrl #(
    parameter logic [7:0] DIV0_RESULT = 8'hFF
) (
    input  logic                clk,
    input  logic                rst,
    alu_issue_ctrl_if.slave     bus,
    output logic                exec_done,
    output logic                div0_err,
    input  logic [1:0]          dbg_sel,
    output logic [7:0]          dbg_data
);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned NREG   = 4;

    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_CMP = 3'd7;

    typedef struct packed {
        logic [2:0] opr;
        logic       imm;
        logic [1:0] rd;
        logic [1:0] rs;
    } instr_t;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_IMM   = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    instr_t            instr_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] regs [NREG];
    logic [DATA_W-1:0] divisor;
    logic              div0_c;
    logic              ready;
    logic              en;
    logic              imm_en;
    logic              done;

    // Operand reads and the effective divisor
    assign bus.alu_a   = regs[instr_q.rd];
    assign bus.alu_b   = regs[instr_q.rs];
    assign bus.alu_opr = instr_q.opr;
    assign bus.alu_imm = imm_q;
    assign divisor     = instr_q.imm ? imm_q : regs[instr_q.rs];
    assign div0_c      = (instr_q.opr == OP_DIV) && (divisor == DATA_W'(0));
    assign dbg_data    = regs[dbg_sel];

    assign bus.instr_ready = ready;
    assign bus.alu_en      = en;
    assign bus.alu_imm_en  = imm_en;
    assign exec_done       = done;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and control decode; reset masks all handshake/strobe outputs
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        en      = 1'b0;
        imm_en  = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_FETCH: begin
                ready = 1'b1;
                if (bus.instr_valid) begin
                    state_d = bus.instr_data[4] ? S_IMM : S_EXEC;
                end
            end
            S_IMM: begin
                ready = 1'b1;
                if (bus.instr_valid) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                en      = !div0_c;
                imm_en  = instr_q.imm;
                done    = 1'b1;
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
        if (rst) begin
            ready  = 1'b0;
            en     = 1'b0;
            imm_en = 1'b0;
            done   = 1'b0;
        end
    end

    // Instruction/immediate latches, register file writeback, div0 flag
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q  <= '0;
            imm_q    <= '0;
            div0_err <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (state_q == S_FETCH && bus.instr_valid) begin
                instr_q <= instr_t'(bus.instr_data);
            end
            if (state_q == S_IMM && bus.instr_valid) begin
                imm_q <= bus.instr_data;
            end
            if (state_q == S_EXEC) begin
                if (div0_c) begin
                    regs[instr_q.rd] <= DIV0_RESULT;
                    div0_err         <= 1'b1;
                end else if (instr_q.opr != OP_CMP) begin
                    regs[instr_q.rd] <= bus.alu_result;
                end
            end
        end
    end
endmodule
